// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry pipeline register (main + skid) with a
// registered ready, synchronous flush and a saturating bubble counter.
// The skid entry absorbs the one beat that upstream may already have
// launched when downstream stalls, so in_ready_o never depends
// combinationally on out_ready_i.
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic accept;
  logic xfer;
  logic bubble;

  assign in_entry = '{valid: 1'b1, ctrl: in_ctrl_i, data: in_data_i};

  // Ready comes straight from the skid register: a full skid is the only
  // reason to refuse a beat.
  assign accept = in_valid_i & ~skid_q.valid & ~flush_i;
  assign xfer   = main_q.valid & out_ready_i;
  assign bubble = out_ready_i & ~main_q.valid;

  // Next-state selection for the two entries; flush overrides everything.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) begin
      main_d = '0;
      skid_d = '0;
    end else if (!main_q.valid || xfer) begin
      // Main is free this edge. The skid can only be occupied while main
      // is valid, and accept is impossible while the skid is full, so the
      // two branches below never compete for main.
      if (skid_q.valid) begin
        main_d = skid_q;
        skid_d = '0;
      end else if (accept) begin
        main_d = in_entry;
      end else begin
        // Going empty: drop ctrl so no write enable leaks from a bubble;
        // data is left as it was.
        main_d.valid = 1'b0;
        main_d.ctrl  = '0;
      end
    end else if (accept) begin
      // Main is stalled: park the new beat in the skid, main holds.
      skid_d = in_entry;
    end
  end

  // Saturating count of cycles where downstream was ready but starved.
  always_comb begin
    bubble_d = bubble_q;
    if (bubble && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset clearing both entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the reset clears every field, data included, so nothing stale can surface after release.
    if (rst_i) begin
      main_q   <= '0;
      skid_q   <= '0;
      bubble_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      main_q   <= main_d;
      skid_q   <= skid_d;
      bubble_q <= bubble_d;
    end
  end

  assign in_ready_o   = ~skid_q.valid;
  assign out_valid_o  = main_q.valid;
  assign out_ctrl_o   = main_q.ctrl;
  assign out_data_o   = main_q.data;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vectors against a queue-based model of the
// stage, checked every falling edge, plus literal expectations for the
// streaming, backpressure, flush, bubble and async-reset scenarios.
module tb_pipe_stage_skid;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic [CTRL_W-1:0] in_ctrl_i = '0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              out_ready_i = 1'b0;

  logic              in_ready_o, out_valid_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic [15:0]       bubble_cnt_o;

  logic              in_ready2, out_valid2;
  logic [CTRL_W-1:0] out_ctrl2;
  logic [DATA_W-1:0] out_data2;
  logic [1:0]        bubble_cnt2;

  pipe_stage_skid dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  pipe_stage_skid #(.CNT_W(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready2),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid2), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl2), .out_data_o(out_data2),
    .bubble_cnt_o(bubble_cnt2)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of depth 2 between the handshakes.
  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t mq[$];
  int    m_bub  = 0;
  int    m_bub2 = 0;

  task automatic model_edge();
    automatic int n = mq.size();
    if (out_ready_i && n == 0) begin
      if (m_bub < 65535) m_bub++;
      if (m_bub2 < 3) m_bub2++;
    end
    if (flush_i) begin
      mq.delete();
    end else begin
      if (n > 0 && out_ready_i) void'(mq.pop_front());
      if (in_valid_i && n < 2) mq.push_back('{ctrl: in_ctrl_i, data: in_data_i});
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_bub  = 0;
    m_bub2 = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; the model advances on the edge.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic r, input logic f);
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, '0, '0, r, 1'b0);
  endtask

  // Compare both instances against the model on every falling edge out of reset.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      logic              e_valid;
      logic [CTRL_W-1:0] e_ctrl;
      logic [DATA_W-1:0] e_data;
      e_valid = (mq.size() != 0);
      e_ctrl  = e_valid ? mq[0].ctrl : '0;
      e_data  = e_valid ? mq[0].data : '0;
      check("out_valid", out_valid_o, e_valid);
      check("in_ready", in_ready_o, mq.size() < 2);
      check("out_ctrl", out_ctrl_o, e_ctrl);
      if (e_valid) check("out_data", out_data_o, e_data);
      check("bubble_cnt", bubble_cnt_o, m_bub);
      check("out_valid_w2", out_valid2, e_valid);
      check("in_ready_w2", in_ready2, mq.size() < 2);
      check("out_ctrl_w2", out_ctrl2, e_ctrl);
      if (e_valid) check("out_data_w2", out_data2, e_data);
      check("bubble_cnt_w2", bubble_cnt2, m_bub2);
    end
  end

  localparam logic [DATA_W-1:0] D1 = 96'hA1A1_0000_0000_0000_0000_0001;
  localparam logic [DATA_W-1:0] D2 = 96'hB2B2_0000_0000_0000_0000_0002;
  localparam logic [DATA_W-1:0] D3 = 96'hC3C3_0000_0000_0000_0000_0003;
  localparam logic [DATA_W-1:0] D4 = 96'hD4D4_0000_0000_0000_0000_0004;
  localparam logic [DATA_W-1:0] D7 = 96'h7777_0000_0000_0000_0000_0007;
  localparam logic [DATA_W-1:0] D8 = 96'h8888_0000_0000_0000_0000_0008;
  localparam logic [DATA_W-1:0] D9 = 96'h9999_0000_0000_0000_0000_0009;

  initial begin
    // Reset held: outputs must be at their reset values.
    #3;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_ctrl", out_ctrl_o, 16'h0);
    check("rst_out_data", out_data_o, 96'h0);
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_bubble", bubble_cnt_o, 16'h0);
    #9 rst_i = 1'b0;
    model_reset();

    // Bubble counter: ready, nothing offered, five edges.
    for (int i = 1; i <= 5; i++) begin
      idle(1'b1);
      check("bub_w2_lit", bubble_cnt2, (i < 3) ? i : 3);
      check("bub_w16_lit", bubble_cnt_o, i);
    end

    // Streaming D1..D4 with out_ready held high.
    step(1'b1, 16'h0011, D1, 1'b1, 1'b0);
    check("stream_d1", out_data_o, D1);
    check("stream_c1", out_ctrl_o, 16'h0011);
    step(1'b1, 16'h0022, D2, 1'b1, 1'b0);
    check("stream_d2", out_data_o, D2);
    check("stream_rdy", in_ready_o, 1'b1);
    step(1'b1, 16'h0033, D3, 1'b1, 1'b0);
    check("stream_d3", out_data_o, D3);
    step(1'b1, 16'h0044, D4, 1'b1, 1'b0);
    check("stream_d4", out_data_o, D4);
    check("stream_rdy4", in_ready_o, 1'b1);
    idle(1'b1);
    check("stream_drain", out_valid_o, 1'b0);
    check("stream_drain_ctrl", out_ctrl_o, 16'h0);

    // Backpressure: D1 held, D2 skidded, D3 refused until release.
    step(1'b1, 16'h0101, D1, 1'b1, 1'b0);
    step(1'b1, 16'h0202, D2, 1'b0, 1'b0);
    check("bp_hold_d1", out_data_o, D1);
    check("bp_not_ready", in_ready_o, 1'b0);
    step(1'b1, 16'h0303, D3, 1'b0, 1'b0);
    check("bp_still_d1", out_data_o, D1);
    step(1'b1, 16'h0303, D3, 1'b1, 1'b0);
    check("bp_rel_d2", out_data_o, D2);
    check("bp_rel_ready", in_ready_o, 1'b1);
    step(1'b1, 16'h0303, D3, 1'b1, 1'b0);
    check("bp_rel_d3", out_data_o, D3);
    idle(1'b1);
    check("bp_empty", out_valid_o, 1'b0);

    // Flush with skid full and D9 presented: everything vanishes.
    step(1'b1, 16'h0707, D7, 1'b0, 1'b0);
    step(1'b1, 16'h0808, D8, 1'b0, 1'b0);
    step(1'b1, 16'h0909, D9, 1'b1, 1'b1);
    check("fl_valid", out_valid_o, 1'b0);
    check("fl_ctrl", out_ctrl_o, 16'h0);
    check("fl_data", out_data_o, 96'h0);
    check("fl_ready", in_ready_o, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush while an accept would otherwise be possible: beat discarded.
    step(1'b1, 16'h0707, D7, 1'b0, 1'b0);
    step(1'b1, 16'h0909, D9, 1'b0, 1'b1);
    check("fl2_valid", out_valid_o, 1'b0);
    idle(1'b1);

    // Async reset mid-cycle with both entries full.
    step(1'b1, 16'h0A0A, D1, 1'b0, 1'b0);
    step(1'b1, 16'h0B0B, D2, 1'b0, 1'b0);
    check("ar_full", in_ready_o, 1'b0);
    #3 rst_i = 1'b1;
    #1;
    check("ar_valid", out_valid_o, 1'b0);
    check("ar_ctrl", out_ctrl_o, 16'h0);
    check("ar_ready", in_ready_o, 1'b1);
    check("ar_bubble", bubble_cnt_o, 16'h0);
    model_reset();
    #2 rst_i = 1'b0;
    idle(1'b1);
    check("ar_no_beat", out_valid_o, 1'b0);

    // Mixed traffic, stalls and occasional flushes, checked by the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom),
           {$urandom, $urandom, $urandom},
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("end_empty", out_valid_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
